// File: rtl/msrv32_pkg.sv
// Shared msrv32 pipeline constants: canonical NOP encoding and RV32 field bit positions.
package msrv32_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int RD_LSB     = 7;
   localparam int RD_MSB     = 11;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_MSB = 14;
   localparam int RS1_LSB    = 15;
   localparam int RS1_MSB    = 19;
   localparam int RS2_LSB    = 20;
   localparam int RS2_MSB    = 24;
   localparam int FUNCT7_LSB = 25;
   localparam int FUNCT7_MSB = 31;
   localparam int CSR_LSB    = 20;
   localparam int CSR_MSB    = 31;

endpackage

// File: rtl/msrv32_instr_field_decode.sv
// Pure combinational split of a 32-bit RV32 instruction word into its decode fields.
module msrv32_instr_field_decode
   import msrv32_pkg::*;
(
   input  logic [31:0] i_word,
   output logic [6:0]  o_opcode,
   output logic [2:0]  o_funct3,
   output logic [6:0]  o_funct7,
   output logic [4:0]  o_rs1addr,
   output logic [4:0]  o_rs2addr,
   output logic [4:0]  o_rdaddr,
   output logic [11:0] o_csr_addr,
   output logic [24:0] o_instr
);

   assign o_opcode   = i_word[OPCODE_MSB:OPCODE_LSB];
   assign o_funct3   = i_word[FUNCT3_MSB:FUNCT3_LSB];
   assign o_funct7   = i_word[FUNCT7_MSB:FUNCT7_LSB];
   assign o_rs1addr  = i_word[RS1_MSB:RS1_LSB];
   assign o_rs2addr  = i_word[RS2_MSB:RS2_LSB];
   assign o_rdaddr   = i_word[RD_MSB:RD_LSB];
   assign o_csr_addr = i_word[CSR_MSB:CSR_LSB];
   // Everything above the opcode, handed to later stages for immediate extraction.
   assign o_instr    = i_word[31:RD_LSB];

endmodule

// File: rtl/msrv32_instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {instr, pc} with the head
// entry presented pre-decoded, and the canonical NOP shown whenever nothing is valid.
module msrv32_instr_queue #(
   parameter int          DEPTH     = 4,
   parameter int          PC_W      = 32,
   parameter logic [31:0] NOP_INSTR = msrv32_pkg::NOP_INSTR
) (
   input  logic                   ms_riscv32_mp_clk_in,
   input  logic                   ms_riscv32_mp_rst_in,
   input  logic                   flush_in,
   input  logic                   instr_valid_in,
   input  logic [31:0]            instr_in,
   input  logic [PC_W-1:0]        pc_in,
   output logic                   instr_ready_out,
   input  logic                   dec_ready_in,
   output logic                   dec_valid_out,
   output logic [6:0]             opcode_out,
   output logic [2:0]             funct3_out,
   output logic [6:0]             funct7_out,
   output logic [4:0]             rs1addr_out,
   output logic [4:0]             rs2addr_out,
   output logic [4:0]             rdaddr_out,
   output logic [11:0]            csr_addr_out,
   output logic [24:0]            instr_out,
   output logic [PC_W-1:0]        pc_out,
   output logic [$clog2(DEPTH):0] count_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      r_mem_instr [DEPTH];
   logic [PC_W-1:0]  r_mem_pc    [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_push;
   logic             w_pop;
   logic [31:0]      w_head;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high; neither side may make valid depend on ready. instr_ready_out comes from
   // registered state only, and flush_in suppresses both transfers in its cycle.
   assign instr_ready_out = !ms_riscv32_mp_rst_in && (r_count < CNT_W'(DEPTH));
   assign dec_valid_out   = (r_count != '0) && !flush_in;
   assign w_push          = instr_valid_in && instr_ready_out && !flush_in;
   assign w_pop           = dec_valid_out && dec_ready_in;

   assign w_head    = dec_valid_out ? r_mem_instr[r_rd_ptr] : NOP_INSTR;
   assign pc_out    = dec_valid_out ? r_mem_pc[r_rd_ptr] : '0;
   assign count_out = r_count;

   // Storage is intentionally unreset; occupancy alone decides what is valid.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (w_push) begin
         r_mem_instr[r_wr_ptr] <= instr_in;
         r_mem_pc[r_wr_ptr]    <= pc_in;
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in || flush_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   msrv32_instr_field_decode u_field_decode (
      .i_word     (w_head),
      .o_opcode   (opcode_out),
      .o_funct3   (funct3_out),
      .o_funct7   (funct7_out),
      .o_rs1addr  (rs1addr_out),
      .o_rs2addr  (rs2addr_out),
      .o_rdaddr   (rdaddr_out),
      .o_csr_addr (csr_addr_out),
      .o_instr    (instr_out)
   );

endmodule

// File: tb/tb_msrv32_instr_queue.sv
// Self-checking bench for msrv32_instr_queue against a queue-based reference model.
module tb_msrv32_instr_queue;

   localparam int          DEPTH = 4;
   localparam int          PC_W  = 32;
   localparam int          CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              ivalid;
   logic [31:0]       instr;
   logic [PC_W-1:0]   pc;
   logic              iready;
   logic              dready;
   logic              dvalid;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [4:0]        rd;
   logic [11:0]       csr;
   logic [24:0]       iout;
   logic [PC_W-1:0]   pcout;
   logic [CW-1:0]     count;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: entries in arrival order, head at index 0.
   logic [31:0]     m_instr_q[$];
   logic [PC_W-1:0] m_pc_q[$];

   always #5 clk = ~clk;

   msrv32_instr_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .NOP_INSTR(NOP)) dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .flush_in             (flush),
      .instr_valid_in       (ivalid),
      .instr_in             (instr),
      .pc_in                (pc),
      .instr_ready_out      (iready),
      .dec_ready_in         (dready),
      .dec_valid_out        (dvalid),
      .opcode_out           (opcode),
      .funct3_out           (funct3),
      .funct7_out           (funct7),
      .rs1addr_out          (rs1),
      .rs2addr_out          (rs2),
      .rdaddr_out           (rd),
      .csr_addr_out         (csr),
      .instr_out            (iout),
      .pc_out               (pcout),
      .count_out            (count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic v,
                        input logic [31:0] w, input logic [PC_W-1:0] p, input logic d);
      rst    = r;
      flush  = f;
      ivalid = v;
      instr  = w;
      pc     = p;
      dready = d;
   endtask

   task automatic check_model();
      logic            exp_valid;
      logic [31:0]     exp_word;
      logic [PC_W-1:0] exp_pc;
      exp_valid = (m_instr_q.size() != 0) && !flush;
      exp_word  = exp_valid ? m_instr_q[0] : NOP;
      exp_pc    = exp_valid ? m_pc_q[0] : '0;
      chk("dec_valid", 32'(dvalid), 32'(exp_valid));
      chk("instr_ready", 32'(iready), 32'(!rst && (m_instr_q.size() < DEPTH)));
      chk("count", 32'(count), 32'(m_instr_q.size()));
      chk("opcode", 32'(opcode), 32'(exp_word[6:0]));
      chk("funct3", 32'(funct3), 32'(exp_word[14:12]));
      chk("funct7", 32'(funct7), 32'(exp_word[31:25]));
      chk("rs1", 32'(rs1), 32'(exp_word[19:15]));
      chk("rs2", 32'(rs2), 32'(exp_word[24:20]));
      chk("rd", 32'(rd), 32'(exp_word[11:7]));
      chk("csr", 32'(csr), 32'(exp_word[31:20]));
      chk("instr_out", 32'(iout), 32'(exp_word[31:7]));
      chk("pc_out", pcout, exp_pc);
   endtask

   // Advance one clock edge and apply the queue semantics to the model.
   task automatic clock_edge();
      logic do_push;
      logic do_pop;
      do_pop  = !rst && !flush && dready && (m_instr_q.size() != 0);
      do_push = !rst && !flush && ivalid && (m_instr_q.size() < DEPTH);
      @(posedge clk);
      if (rst || flush) begin
         m_instr_q.delete();
         m_pc_q.delete();
      end else begin
         if (do_pop) begin
            void'(m_instr_q.pop_front());
            void'(m_pc_q.pop_front());
         end
         if (do_push) begin
            m_instr_q.push_back(instr);
            m_pc_q.push_back(pc);
         end
      end
      @(negedge clk);
   endtask

   task automatic step(input logic r, input logic f, input logic v,
                       input logic [31:0] w, input logic [PC_W-1:0] p, input logic d);
      drive(r, f, v, w, p, d);
      #1;
      check_model();
      clock_edge();
   endtask

   task automatic idle_check();
      drive(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0);
      #1;
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, '0, 1'b0);
      @(negedge clk);
      clock_edge();
      m_instr_q.delete();
      m_pc_q.delete();

      // Reset state while idle
      idle_check();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(dvalid), 32'd0);
      chk("rst_opcode", 32'(opcode), 32'h13);
      chk("rst_rd", 32'(rd), 32'd0);
      chk("rst_pc", pcout, 32'h0);
      chk("rst_ready", 32'(iready), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0);

      // Single push of addi x1,x0,5
      step(1'b0, 1'b0, 1'b1, 32'h0050_0093, 32'h100, 1'b0);
      idle_check();
      chk("addi_valid", 32'(dvalid), 32'd1);
      chk("addi_opcode", 32'(opcode), 32'h13);
      chk("addi_rd", 32'(rd), 32'd1);
      chk("addi_funct3", 32'(funct3), 32'd0);
      chk("addi_csr", 32'(csr), 32'h005);
      chk("addi_pc", pcout, 32'h100);
      chk("addi_count", 32'(count), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1);

      // Fill to DEPTH, attempt a fifth push, then drain
      for (int i = 0; i < DEPTH + 1; i++)
         step(1'b0, 1'b0, 1'b1, $urandom, PC_W'(32'h200 + 4 * i), 1'b0);
      idle_check();
      chk("full_count", 32'(count), 32'(DEPTH));
      chk("full_ready", 32'(iready), 32'd0);
      for (int i = 0; i < DEPTH + 1; i++)
         step(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1);
      idle_check();
      chk("drained_valid", 32'(dvalid), 32'd0);

      // Sustained streaming from empty wraps the pointers
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b0, 1'b1, $urandom, PC_W'(32'h300 + 4 * i), 1'b1);
      idle_check();
      chk("stream_count", 32'(count), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1);

      // Flush with push and pop offered in the same cycle
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b1, $urandom, PC_W'(32'h400 + 4 * i), 1'b0);
      drive(1'b0, 1'b1, 1'b1, 32'hdead_beef, 32'h500, 1'b1);
      #1;
      chk("flush_valid", 32'(dvalid), 32'd0);
      chk("flush_opcode", 32'(opcode), 32'h13);
      chk("flush_pc", pcout, 32'h0);
      check_model();
      clock_edge();
      idle_check();
      chk("post_flush_count", 32'(count), 32'd0);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1);

      // Reset mid-stream with two entries held, then resume
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'b0, 1'b1, $urandom, PC_W'(32'h600 + 4 * i), 1'b0);
      step(1'b1, 1'b0, 1'b1, $urandom, 32'h700, 1'b1);
      idle_check();
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_valid", 32'(dvalid), 32'd0);
      chk("mid_rst_opcode", 32'(opcode), 32'h13);
      chk("mid_rst_ready", 32'(iready), 32'd1);
      step(1'b0, 1'b0, 1'b1, 32'h0020_8133, 32'h800, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b1);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
              1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
